// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the instruction pointer, drives instr_fetch and issues words to execute.
// Optional feature macro: FETCH_SINGLE_STEP_EN (adds step input and WAIT_STEP gating).
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   fetch_enable      instr_fetch latches the word at pointer on this edge
//   pointer           current ip, always presented to instr_fetch
//   instr_valid       an unconsumed fetched instruction is on offer
//   instr_ready       execute accepts the offered instruction
//   branch_taken      with accept, redirect ip to branch_target
//   branch_target     redirect address
//   halt              with accept, park in HALTED after this instruction
//   halted            sequencer is parked until reset
//   step              single-step pulse (macro build only)
//   retired           count of accepted instructions
module fetch_sequencer #(
    parameter int WORD_SIZE    = 16,
    parameter int RESET_VECTOR = 0,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   fetch_enable,
    output logic [WORD_SIZE-1:0]   pointer,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    input  logic                   branch_taken,
    input  logic [WORD_SIZE-1:0]   branch_target,
    input  logic                   halt,
    output logic                   halted,
`ifdef FETCH_SINGLE_STEP_EN
    input  logic                   step,
`endif
    output logic [COUNT_WIDTH-1:0] retired
);
    typedef enum logic [1:0] {FETCH, ISSUE, HALTED, WAIT_STEP} state_t;
    state_t state, next_state;
    logic [WORD_SIZE-1:0] ip;
    logic accept;
    logic step_go;
`ifdef FETCH_SINGLE_STEP_EN
    localparam state_t RESET_STATE  = WAIT_STEP;
    localparam state_t AFTER_ACCEPT = WAIT_STEP;
    assign step_go = step;
`else
    localparam state_t RESET_STATE  = FETCH;
    localparam state_t AFTER_ACCEPT = FETCH;
    assign step_go = 1'b0;
`endif
    assign fetch_enable = (state == FETCH);
    assign instr_valid  = (state == ISSUE);
    assign halted       = (state == HALTED);
    assign pointer      = ip;
    always_comb begin
        accept     = (state == ISSUE) && instr_ready;
        next_state = state;
        if (state == FETCH)
            next_state = ISSUE;
        else if (accept)
            next_state = halt ? HALTED : AFTER_ACCEPT;
        else if (state == WAIT_STEP && step_go)
            next_state = FETCH;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= RESET_STATE;
            ip      <= WORD_SIZE'(RESET_VECTOR);
            retired <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                retired <= retired + 1'b1;
                ip      <= branch_taken ? branch_target : ip + 1'b1;
            end
        end
    end
endmodule
